// File: rtl/deflate_lane_pkg.sv
// deflate_lane_pkg: lane count, select width and lane decode helpers shared by the scatter stage.
package deflate_lane_pkg;
   localparam int LANES = 32;
   localparam int LANE_SEL_W = 5;
   typedef logic [LANE_SEL_W-1:0] lane_sel_t;
   typedef logic [LANES-1:0] lane_mask_t;
   function automatic lane_mask_t lane_onehot(input lane_sel_t s);
      return lane_mask_t'(1) << s;
   endfunction
endpackage

// File: rtl/demux_1to32_reg_lane_slot.sv
// lane_slot: one-entry holding register; a load wins over a drain so write+drain never bubbles.
module lane_slot #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         drain,
   input  logic [N-1:0] din,
   output logic [N-1:0] data,
   output logic         valid
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data  <= '0;
         valid <= 1'b0;
      end else if (load) begin
         data  <= din;
         valid <= 1'b1;
      end else if (drain) begin
         valid <= 1'b0;
      end
   end
endmodule

// File: rtl/demux_1to32_reg.sv
// demux_1to32_reg: registered 1-to-32 scatter with explicit, round-robin or broadcast lane choice.
module demux_1to32_reg
   import deflate_lane_pkg::*;
#(
   parameter int N = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N-1:0]      din,
   input  lane_sel_t         din_sel,
   input  logic              din_bcast,
   input  logic              rr_mode,
   input  logic              din_valid,
   output logic              din_ready,
   output logic [LANES*N-1:0] dout,
   output lane_mask_t        dout_valid,
   input  lane_mask_t        dout_ready,
   output lane_sel_t         rr_ptr
);
   lane_sel_t  tgt;
   lane_mask_t lane_free;
   lane_mask_t load;
   logic       accept;
   // broadcast only proceeds when every lane can take it, keeping it atomic
   always_comb begin
      tgt       = rr_mode ? rr_ptr : din_sel;
      lane_free = ~dout_valid | dout_ready;
      din_ready = rst_n & (din_bcast ? &lane_free : lane_free[tgt]);
      accept    = din_valid & din_ready;
      load      = accept ? (din_bcast ? '1 : lane_onehot(tgt)) : '0;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rr_ptr <= '0;
      else if (accept && !din_bcast && rr_mode)
         rr_ptr <= rr_ptr + 1'b1;
   end
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      lane_slot #(.N(N)) u_slot (
         .clk  (clk),
         .rst_n(rst_n),
         .load (load[i]),
         .drain(dout_ready[i]),
         .din  (din),
         .data (dout[i*N +: N]),
         .valid(dout_valid[i])
      );
   end
endmodule

// File: tb/tb_demux_1to32_reg.sv
// tb_demux_1to32_reg: directed table, round-robin wrap, random traffic and async reset against a lane-array model.
module tb_demux_1to32_reg;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [7:0]   din = '0;
   logic [4:0]   din_sel = '0;
   logic         din_bcast = 1'b0;
   logic         rr_mode = 1'b0;
   logic         din_valid = 1'b0;
   logic         din_ready;
   logic [255:0] dout;
   logic [31:0]  dout_valid;
   logic [31:0]  dout_ready = '1;
   logic [4:0]   rr_ptr;
   int total = 0;
   int bad = 0;
   logic [7:0] md [32];
   bit         mv [32];
   int         m_ptr;

   demux_1to32_reg #(.N(8)) dut (
      .clk(clk), .rst_n(rst_n), .din(din), .din_sel(din_sel), .din_bcast(din_bcast),
      .rr_mode(rr_mode), .din_valid(din_valid), .din_ready(din_ready), .dout(dout),
      .dout_valid(dout_valid), .dout_ready(dout_ready), .rr_ptr(rr_ptr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  d;
      logic [4:0]  sel;
      bit          bc;
      bit          v;
      logic [31:0] rdy;
      bit          exp_rdy;
      int          lane;
      logic [7:0]  exp_d;
      bit          exp_v;
   } vec_t;
   vec_t tbl [14];

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic bit model_ready();
      bit all_free = 1'b1;
      int t = rr_mode ? m_ptr : int'(din_sel);
      for (int i = 0; i < 32; i++)
         if (mv[i] && !dout_ready[i]) all_free = 1'b0;
      return din_bcast ? all_free : (!mv[t] || dout_ready[t]);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         md[i] = '0;
         mv[i] = 1'b0;
      end
      m_ptr = 0;
   endtask

   task automatic model_update();
      bit acc = din_valid && model_ready();
      int t = rr_mode ? m_ptr : int'(din_sel);
      for (int i = 0; i < 32; i++) begin
         if (acc && (din_bcast || t == i)) begin
            md[i] = din;
            mv[i] = 1'b1;
         end else if (dout_ready[i]) mv[i] = 1'b0;
      end
      if (acc && !din_bcast && rr_mode) m_ptr = (m_ptr + 1) % 32;
   endtask

   task automatic chk_outputs();
      logic [255:0] ed;
      logic [31:0]  ev;
      for (int i = 0; i < 32; i++) begin
         ed[i*8 +: 8] = md[i];
         ev[i] = mv[i];
      end
      chk("dout_valid", dout_valid, ev);
      chk("dout", dout, ed);
      chk("rr_ptr", rr_ptr, m_ptr);
   endtask

   // inputs are already driven at posedge+1; check din_ready mid-cycle, then registered outputs after the edge
   task automatic cycle();
      #3;
      chk("din_ready", din_ready, model_ready());
      @(posedge clk);
      model_update();
      #1;
      chk_outputs();
   endtask

   initial begin
      tbl[0]  = '{8'h11, 5'd3,  0, 1, 32'hFFFF_FFFF, 1, 3,  8'h11, 1};
      tbl[1]  = '{8'h22, 5'd31, 0, 1, 32'hFFFF_FFFF, 1, 31, 8'h22, 1};
      tbl[2]  = '{8'h00, 5'd3,  0, 0, 32'hFFFF_FFFF, 1, 3,  8'h11, 0};
      tbl[3]  = '{8'hA0, 5'd5,  0, 1, 32'hFFFF_FFDF, 1, 5,  8'hA0, 1};
      tbl[4]  = '{8'hA1, 5'd5,  0, 1, 32'hFFFF_FFDF, 0, 5,  8'hA0, 1};
      tbl[5]  = '{8'hB6, 5'd6,  0, 1, 32'hFFFF_FFDF, 1, 6,  8'hB6, 1};
      tbl[6]  = '{8'hA1, 5'd5,  0, 1, 32'hFFFF_FFFF, 1, 5,  8'hA1, 1};
      tbl[7]  = '{8'h01, 5'd2,  0, 1, 32'hFFFF_FFFF, 1, 2,  8'h01, 1};
      tbl[8]  = '{8'h02, 5'd2,  0, 1, 32'hFFFF_FFFF, 1, 2,  8'h02, 1};
      tbl[9]  = '{8'h00, 5'd2,  0, 0, 32'hFFFF_FFFF, 1, 2,  8'h02, 0};
      tbl[10] = '{8'h99, 5'd9,  0, 1, 32'hFFFF_FDFF, 1, 9,  8'h99, 1};
      tbl[11] = '{8'h5A, 5'd4,  1, 1, 32'hFFFF_FDFF, 0, 9,  8'h99, 1};
      tbl[12] = '{8'h5A, 5'd4,  1, 1, 32'hFFFF_FFFF, 1, 17, 8'h5A, 1};
      tbl[13] = '{8'h00, 5'd31, 0, 0, 32'hFFFF_FFFF, 1, 31, 8'h5A, 0};
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("reset_din_ready", din_ready, 1'b0);
      chk_outputs();
      rst_n = 1'b1;
      for (int k = 0; k < 14; k++) begin
         din = tbl[k].d; din_sel = tbl[k].sel; din_bcast = tbl[k].bc;
         din_valid = tbl[k].v; dout_ready = tbl[k].rdy; rr_mode = 1'b0;
         #2;
         chk($sformatf("tbl%0d_ready", k), din_ready, tbl[k].exp_rdy);
         cycle();
         chk($sformatf("tbl%0d_data", k), dout[tbl[k].lane*8 +: 8], tbl[k].exp_d);
         chk($sformatf("tbl%0d_valid", k), dout_valid[tbl[k].lane], tbl[k].exp_v);
      end
      chk("bcast_ptr", rr_ptr, 5'd0);
      // round-robin wrap: word k to lane k mod 32
      rr_mode = 1'b1; din_bcast = 1'b0; din_valid = 1'b1; dout_ready = '1;
      for (int k = 0; k < 33; k++) begin
         din = 8'(k);
         din_sel = 5'($urandom);
         cycle();
         chk($sformatf("rr%0d_data", k), dout[(k % 32)*8 +: 8], 8'(k));
         chk($sformatf("rr%0d_valid", k), dout_valid[k % 32], 1'b1);
      end
      chk("rr_end_ptr", rr_ptr, 5'd1);
      for (int k = 0; k < 400; k++) begin
         din = 8'($urandom);
         din_sel = 5'($urandom);
         din_bcast = ($urandom_range(0, 9) == 0);
         rr_mode = 1'($urandom);
         din_valid = ($urandom_range(0, 3) != 0);
         dout_ready = $urandom | $urandom;
         if ($urandom_range(0, 7) == 0) dout_ready = '1;
         cycle();
      end
      // reset mid-stream with lanes 0..7 held and rr_ptr at 8
      #3 rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      rr_mode = 1'b1; din_bcast = 1'b0; din_valid = 1'b1; dout_ready = '0;
      for (int k = 0; k < 8; k++) begin
         din = 8'(8'hC0 + k);
         cycle();
      end
      chk("pre_reset_ptr", rr_ptr, 5'd8);
      chk("pre_reset_valid", dout_valid, 32'h0000_00FF);
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      chk("async_din_ready", din_ready, 1'b0);
      chk_outputs();
      @(posedge clk);
      #3 rst_n = 1'b1;
      #1;
      chk("release_din_ready", din_ready, 1'b1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
